// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// The sub field exists only when NIBBLE_SERIAL_ADDER_CTRL_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;

`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    modport master (
        output in_valid, a, b, c, sub, out_ready,
        input  in_ready, out_valid, out
    );
    modport slave (
        input  in_valid, a, b, c, sub, out_ready,
        output in_ready, out_valid, out
    );
`else
    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, out
    );
    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, out
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit add slice, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_ADDER_CTRL_SUB_EN to add the sub (a-b) operand mode.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    nibble_serial_adder_ctrl_if.slave        bus,
    output logic                             busy
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx;
    logic [WIDTH:0]   out_r;
    logic             out_valid_r;
    logic             accept;
    logic             sub_in;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;

`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.in_valid;

    // The single shared 4-bit add slice, fed by the nibble selected by idx.
    assign a_nib   = a_r[{idx, 2'b00} +: 4];
    assign b_nib   = b_r[{idx, 2'b00} +: 4];
    assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no branch leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST_IDX)  state_nxt = DONE;
            DONE:    if (bus.out_ready)    state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == IDLE);
        busy         = (state != IDLE);
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;

    // Datapath: operand capture, per-nibble write-back and result handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            idx         <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                a_r     <= bus.a;
                b_r     <= sub_in ? ~bus.b : bus.b;
                carry_r <= sub_in ? 1'b1 : bus.c;
                idx     <= '0;
            end

            if (state == RUN) begin
                out_r[{idx, 2'b00} +: 4] <= nib_sum[3:0];
                carry_r                  <= nib_sum[4];
                if (idx == LAST_IDX) begin
                    out_r[WIDTH] <= nib_sum[4];
                    out_valid_r  <= 1'b1;
                    idx          <= '0;
                end else begin
                    idx <= idx + IDXW'(1);
                end
            end

            if (state == DONE && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl at WIDTH = 8, 16 and 4.
// Stimulus pushes hand-computed results and their expected valid edge; monitors pop on each new result.
`timescale 1ns/1ps
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();
    logic busy8, busy16, busy4;

    nibble_serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8),  .busy(busy8));
    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16), .busy(busy16));
    nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4),  .busy(busy4));

    typedef struct {
        logic [16:0] val;
        int unsigned cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q4[$];
    exp_t e8, e16, e4;
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    logic pv8 = 1'b0, pv16 = 1'b0, pv4 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: on each rising out_valid, compare the sum and the edge it appeared on.
    always @(negedge clk) begin
        if (bus8.out_valid === 1'b1 && !pv8) begin
            if (q8.size() == 0) check("w8 unexpected result", 32'(bus8.out_valid), 0);
            else begin
                e8 = q8.pop_front();
                check("w8 sum", 32'(bus8.out), 32'(e8.val[8:0]));
                check("w8 latency", cyc, e8.cyc);
            end
        end
        pv8 = (bus8.out_valid === 1'b1);
    end

    always @(negedge clk) begin
        if (bus16.out_valid === 1'b1 && !pv16) begin
            if (q16.size() == 0) check("w16 unexpected result", 32'(bus16.out_valid), 0);
            else begin
                e16 = q16.pop_front();
                check("w16 sum", 32'(bus16.out), 32'(e16.val));
                check("w16 latency", cyc, e16.cyc);
            end
        end
        pv16 = (bus16.out_valid === 1'b1);
    end

    always @(negedge clk) begin
        if (bus4.out_valid === 1'b1 && !pv4) begin
            if (q4.size() == 0) check("w4 unexpected result", 32'(bus4.out_valid), 0);
            else begin
                e4 = q4.pop_front();
                check("w4 sum", 32'(bus4.out), 32'(e4.val[4:0]));
                check("w4 latency", cyc, e4.cyc);
            end
        end
        pv4 = (bus4.out_valid === 1'b1);
    end

    // All issue tasks are entered at a negedge and return at the negedge after the accept edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic sub, input logic [8:0] exp_v);
        exp_t e;
        int n = 0;
        while (bus8.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check("w8 ready timeout", 32'(bus8.in_ready), 1);
        bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.c = c;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        bus8.sub = sub;
`endif
        e.val = 17'(exp_v); e.cyc = cyc + 1 + 2;
        q8.push_back(e);
        @(negedge clk);
        bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.c = ~c;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        bus8.sub = ~sub;
`endif
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [16:0] exp_v);
        exp_t e;
        int n = 0;
        while (bus16.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check("w16 ready timeout", 32'(bus16.in_ready), 1);
        bus16.in_valid = 1'b1; bus16.a = a; bus16.b = b; bus16.c = c;
        e.val = exp_v; e.cyc = cyc + 1 + 4;
        q16.push_back(e);
        @(negedge clk);
        bus16.in_valid = 1'b0; bus16.a = ~a; bus16.b = ~b; bus16.c = ~c;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [4:0] exp_v);
        exp_t e;
        int n = 0;
        while (bus4.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check("w4 ready timeout", 32'(bus4.in_ready), 1);
        bus4.in_valid = 1'b1; bus4.a = a; bus4.b = b; bus4.c = c;
        e.val = 17'(exp_v); e.cyc = cyc + 1 + 1;
        q4.push_back(e);
        @(negedge clk);
        bus4.in_valid = 1'b0; bus4.a = ~a; bus4.b = ~b; bus4.c = ~c;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.c = 0;  bus8.out_ready = 1;
        bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.c = 0; bus16.out_ready = 1;
        bus4.in_valid = 0;  bus4.a = 0;  bus4.b = 0;  bus4.c = 0;  bus4.out_ready = 1;
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        bus8.sub = 0; bus16.sub = 0; bus4.sub = 0;
`endif
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus8.in_ready), 1);
        check("reset out_valid", 32'(bus8.out_valid), 0);
        check("reset out", 32'(bus8.out), 0);
        check("reset busy", 32'(busy8), 0);
        check("reset w16 in_ready", 32'(bus16.in_ready), 1);
        check("reset w4 busy", 32'(busy4), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with handoff timing; operands change after accept (isolation).
        issue8(8'h5A, 8'hC3, 1'b0, 1'b0, 9'h11D);
        check("basic busy in RUN", 32'(busy8), 1);
        check("basic in_ready in RUN", 32'(bus8.in_ready), 0);
        repeat (2) @(negedge clk);
        check("basic out_valid at k+2", 32'(bus8.out_valid), 1);
        @(negedge clk);
        check("basic out_valid after handoff", 32'(bus8.out_valid), 0);
        check("basic in_ready after handoff", 32'(bus8.in_ready), 1);
        check("basic busy after handoff", 32'(busy8), 0);
        check("basic out held", 32'(bus8.out), 32'h11D);

        // Inter-nibble carry.
        issue8(8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
        drain();
        issue8(8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);
        drain();

        // Backpressure: result held while in_valid/a/b toggle.
        bus8.out_ready = 1'b0;
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 9'h046);
        begin
            int n = 0;
            while (bus8.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            if (n == 20) check("bp valid timeout", 32'(bus8.out_valid), 1);
        end
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = ~bus8.in_valid;
            bus8.a = 8'(i * 37 + 1);
            bus8.b = 8'(i * 91 + 7);
            @(negedge clk);
            check("bp out stable", 32'(bus8.out), 32'h046);
            check("bp out_valid held", 32'(bus8.out_valid), 1);
            check("bp in_ready low", 32'(bus8.in_ready), 0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(bus8.out_valid), 0);
        check("bp release in_ready", 32'(bus8.in_ready), 1);
        repeat (4) begin
            @(negedge clk);
            check("bp no second capture", 32'(busy8), 0);
        end

        // WIDTH=16: full result, then reset mid-run, then reset with in_valid.
        issue16(16'h1234, 16'h4321, 1'b0, 17'h05555);
        drain();
        issue16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        void'(q16.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("w16 rst in_ready", 32'(bus16.in_ready), 1);
        check("w16 rst out", 32'(bus16.out), 0);
        check("w16 rst out_valid", 32'(bus16.out_valid), 0);
        check("w16 rst busy", 32'(busy16), 0);
        bus16.in_valid = 1'b1; bus16.a = 16'hAAAA; bus16.b = 16'h5555;
        @(negedge clk);
        check("w16 rst beats in_valid", 32'(busy16), 0);
        rst = 1'b0;
        bus16.in_valid = 1'b0;
        issue16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        drain();

        // WIDTH=4: single-cycle RUN.
        issue4(4'hF, 4'hF, 1'b1, 5'h1F);
        drain();
        issue4(4'h3, 4'h4, 1'b0, 5'h07);
        drain();

`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        // Subtract: c is ignored when sub=1.
        issue8(8'h05, 8'h07, 1'b1, 1'b1, 9'h0FE);
        drain();
        issue8(8'h07, 8'h05, 1'b0, 1'b1, 9'h102);
        drain();
        issue8(8'h05, 8'h07, 1'b0, 1'b0, 9'h00C);
        drain();
`endif

        check("q8 drained", q8.size(), 0);
        check("q16 drained", q16.size(), 0);
        check("q4 drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
